// File: rtl/sensor_node_ctrl.sv
// Command sequencer moving sensor samples and radio bytes through a circular memory buffer.
// Define SNC_TIMEOUT_EN to bound the wait states with a timeout (err_tmo); otherwise waits never expire.
module sensor_node_ctrl #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned NUM_SENSORS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned CH_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [CH_W-1:0]               cmd_chan,
  output logic [NUM_SENSORS-1:0]        sensor_req,
  input  logic [NUM_SENSORS-1:0]        sensor_valid,
  input  logic [NUM_SENSORS*DATA_W-1:0] sensor_data,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_we,
  output logic                          mem_re,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          radio_enable,
  input  logic                          radio_busy,
  output logic                          radio_send,
  output logic [DATA_W-1:0]             radio_tx_data,
  input  logic                          radio_rx_valid,
  input  logic [DATA_W-1:0]             radio_rx_data,
  output logic [ADDR_W:0]               buf_count,
  output logic                          buf_full,
  output logic                          buf_empty,
  output logic                          err_ovf,
  output logic                          err_udf,
  output logic                          err_tmo
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [1:0] OpSample = 2'b01;
  localparam logic [1:0] OpTx     = 2'b10;
  localparam logic [1:0] OpRx     = 2'b11;

  typedef enum logic [2:0] {
    StIdle, StSense, StRxWait, StMemWr, StMemRd, StRdWait, StTxWait
  } state_e;

  state_e                   state_q, state_d;
  logic [CH_W-1:0]          chan_q, chan_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]          count_q, count_d;
  logic [NUM_SENSORS-1:0]   sensor_req_q, sensor_req_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d, radio_tx_data_q, radio_tx_data_d;
  logic                     mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic                     radio_enable_q, radio_enable_d, radio_send_q, radio_send_d;
  logic                     err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
  logic                     sel_valid;
  logic [DATA_W-1:0]        sel_data;
`ifdef SNC_TIMEOUT_EN
  logic [31:0]              tmo_q, tmo_d;
  logic                     err_tmo_q, err_tmo_d;
  logic                     waiting;
`endif

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      if (chan_q == CH_W'(k)) begin
        sel_valid = sensor_valid[k];
        sel_data  = sensor_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    chan_d          = chan_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    radio_tx_data_d = radio_tx_data_q;
    mem_we_d        = 1'b0;
    mem_re_d        = 1'b0;
    radio_send_d    = 1'b0;
    err_ovf_d       = 1'b0;
    err_udf_d       = 1'b0;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            unique case (cmd_op)
              OpSample, OpRx: begin
                if (buf_full) begin
                  err_ovf_d = 1'b1;
                end else begin
                  state_d = (cmd_op == OpSample) ? StSense : StRxWait;
                  chan_d  = cmd_chan;
                end
              end
              OpTx: begin
                if (buf_empty) begin
                  err_udf_d = 1'b1;
                end else begin
                  state_d    = StMemRd;
                  mem_re_d   = 1'b1;
                  mem_addr_d = rd_ptr_q;
                end
              end
              default: ;
            endcase
          end
        end
        StSense: begin
          if (sel_valid) begin
            state_d     = StMemWr;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_q;
            mem_wdata_d = sel_data;
          end
        end
        StRxWait: begin
          if (radio_rx_valid) begin
            state_d     = StMemWr;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_q;
            mem_wdata_d = radio_rx_data;
          end
        end
        StMemWr: begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          count_d  = count_q + CntW'(1);
          state_d  = StIdle;
        end
        StMemRd: state_d = StRdWait;
        StRdWait: begin
          radio_tx_data_d = mem_rdata;
          state_d         = StTxWait;
          radio_send_d    = !radio_busy;
        end
        StTxWait: begin
          // The send strobe is registered, so the byte is committed while it is on the port.
          if (radio_send_q) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d  = count_q - CntW'(1);
            state_d  = StIdle;
          end else if (!radio_busy) begin
            radio_send_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else begin
      state_d = StIdle;
    end
`ifdef SNC_TIMEOUT_EN
    waiting   = state_q inside {StSense, StRxWait, StTxWait};
    err_tmo_d = 1'b0;
    if (enable && waiting && state_d == state_q && !radio_send_d &&
        tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
      state_d   = StIdle;
      err_tmo_d = 1'b1;
    end
    tmo_d = (waiting && state_d == state_q) ? tmo_q + 32'd1 : 32'd0;
`endif
    sensor_req_d   = (state_d == StSense) ? (NUM_SENSORS'(1) << chan_d) : '0;
    radio_enable_d = state_d inside {StRxWait, StMemRd, StRdWait, StTxWait};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      chan_q          <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      sensor_req_q    <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      radio_tx_data_q <= '0;
      mem_we_q        <= 1'b0;
      mem_re_q        <= 1'b0;
      radio_enable_q  <= 1'b0;
      radio_send_q    <= 1'b0;
      err_ovf_q       <= 1'b0;
      err_udf_q       <= 1'b0;
`ifdef SNC_TIMEOUT_EN
      tmo_q           <= '0;
      err_tmo_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      chan_q          <= chan_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      sensor_req_q    <= sensor_req_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      radio_tx_data_q <= radio_tx_data_d;
      mem_we_q        <= mem_we_d;
      mem_re_q        <= mem_re_d;
      radio_enable_q  <= radio_enable_d;
      radio_send_q    <= radio_send_d;
      err_ovf_q       <= err_ovf_d;
      err_udf_q       <= err_udf_d;
`ifdef SNC_TIMEOUT_EN
      tmo_q           <= tmo_d;
      err_tmo_q       <= err_tmo_d;
`endif
    end
  end

  assign cmd_ready     = enable && (state_q == StIdle);
  assign sensor_req    = sensor_req_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_we        = mem_we_q;
  assign mem_re        = mem_re_q;
  assign radio_enable  = radio_enable_q;
  assign radio_send    = radio_send_q;
  assign radio_tx_data = radio_tx_data_q;
  assign buf_count     = count_q;
  assign buf_full      = (count_q == CntW'(DEPTH));
  assign buf_empty     = (count_q == '0);
  assign err_ovf       = err_ovf_q;
  assign err_udf       = err_udf_q;
`ifdef SNC_TIMEOUT_EN
  assign err_tmo       = err_tmo_q;
`else
  assign err_tmo       = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_node_ctrl.sv
// Directed + randomized bench for sensor_node_ctrl against a queue-based buffer model.
// Build with SNC_TIMEOUT_EN defined to exercise the timeout path instead of the unbounded wait.
module tb_sensor_node_ctrl;

  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        rst_n, enable, cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_chan;
  logic [3:0]  sensor_req, sensor_valid;
  logic [31:0] sensor_data;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata, radio_tx_data, radio_rx_data;
  logic        mem_we, mem_re, radio_enable, radio_busy, radio_send, radio_rx_valid;
  logic [8:0]  buf_count;
  logic        buf_full, buf_empty, err_ovf, err_udf, err_tmo;

  int n_chk = 0, n_fail = 0;
  int n_we_seen = 0, n_send_seen = 0, n_tmo_seen = 0;
  int n_we_exp = 0, n_send_exp = 0, n_tmo_exp = 0;
  logic [7:0] q[$];
  int wr_idx = 0, rd_idx = 0;
  logic [7:0] mem [256];

  sensor_node_ctrl #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(Depth), .NUM_SENSORS(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_chan(cmd_chan), .sensor_req(sensor_req),
    .sensor_valid(sensor_valid), .sensor_data(sensor_data), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .radio_enable(radio_enable), .radio_busy(radio_busy), .radio_send(radio_send),
    .radio_tx_data(radio_tx_data), .radio_rx_valid(radio_rx_valid),
    .radio_rx_data(radio_rx_data), .buf_count(buf_count), .buf_full(buf_full),
    .buf_empty(buf_empty), .err_ovf(err_ovf), .err_udf(err_udf), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  // Single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_we) n_we_seen <= n_we_seen + 1;
    if (radio_send) n_send_seen <= n_send_seen + 1;
    if (err_tmo) n_tmo_seen <= n_tmo_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input int ch);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_chan  = 2'(ch);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  task automatic ovf_checks();
    chk("ovf_pulse", err_ovf, 1);
    chk("ovf_ready", cmd_ready, 1);
    chk("ovf_req", sensor_req, 0);
    chk("ovf_ren", radio_enable, 0);
    @(negedge clk);
    chk("ovf_once", err_ovf, 0);
    chk("ovf_no_we", mem_we, 0);
    chk("ovf_full", buf_full, 1);
  endtask

  task automatic expect_write(input logic [7:0] d);
    chk("we", mem_we, 1);
    chk("we_addr", mem_addr, wr_idx);
    chk("we_data", mem_wdata, d);
    chk("we_req_off", sensor_req, 0);
    q.push_back(d);
    wr_idx = (wr_idx + 1) % Depth;
    n_we_exp++;
  endtask

  task automatic after_write();
    @(negedge clk);
    chk("wr_ready", cmd_ready, 1);
    chk("wr_we_once", mem_we, 0);
    chk("wr_count", buf_count, q.size());
    chk("wr_full", buf_full, q.size() == Depth);
  endtask

  task automatic do_sample(input int ch, input logic [7:0] d, input int dly);
    for (int k = 0; k < 4; k++) sensor_data[k*8 +: 8] = 8'($urandom);
    sensor_data[ch*8 +: 8] = d;
    sensor_valid = 4'($urandom) & ~(4'b0001 << ch);
    if (dly == 0) sensor_valid[ch] = 1'b1;
    issue(2'b01, ch);
    if (q.size() == Depth) begin
      ovf_checks();
      sensor_valid = '0;
      return;
    end
    for (int j = 0; j < dly; j++) begin
      chk("smp_req", sensor_req, 4'b0001 << ch);
      chk("smp_wait_we", mem_we, 0);
      @(negedge clk);
    end
    sensor_valid[ch] = 1'b1;
    chk("smp_req", sensor_req, 4'b0001 << ch);
    @(negedge clk);
    expect_write(d);
    sensor_valid = '0;
    after_write();
  endtask

  task automatic do_rx(input logic [7:0] d, input int dly);
    radio_rx_valid = (dly == 0);
    radio_rx_data  = (dly == 0) ? d : 8'($urandom);
    issue(2'b11, 0);
    if (q.size() == Depth) begin
      ovf_checks();
      radio_rx_valid = 1'b0;
      return;
    end
    for (int j = 0; j < dly; j++) begin
      chk("rx_ren", radio_enable, 1);
      chk("rx_wait_we", mem_we, 0);
      @(negedge clk);
    end
    radio_rx_valid = 1'b1;
    radio_rx_data  = d;
    chk("rx_ren", radio_enable, 1);
    @(negedge clk);
    expect_write(d);
    chk("rx_ren_off", radio_enable, 0);
    radio_rx_valid = 1'b0;
    after_write();
  endtask

  task automatic do_tx(input int b);
    logic [7:0] exp_b;
    radio_busy = (b > 0);
    issue(2'b10, 0);
    if (q.size() == 0) begin
      chk("udf_pulse", err_udf, 1);
      chk("udf_ready", cmd_ready, 1);
      chk("udf_no_re", mem_re, 0);
      @(negedge clk);
      chk("udf_once", err_udf, 0);
      chk("udf_empty", buf_empty, 1);
      chk("udf_no_send", radio_send, 0);
      return;
    end
    chk("re", mem_re, 1);
    chk("re_addr", mem_addr, rd_idx);
    chk("re_ren", radio_enable, 1);
    @(negedge clk);
    chk("re_once", mem_re, 0);
    chk("rd_ren", radio_enable, 1);
    for (int j = 0; j < b; j++) begin
      radio_busy = 1'b1;
      chk("busy_no_send", radio_send, 0);
      @(negedge clk);
    end
    radio_busy = 1'b0;
    chk("pre_send", radio_send, 0);
    @(negedge clk);
    exp_b  = q.pop_front();
    rd_idx = (rd_idx + 1) % Depth;
    n_send_exp++;
    chk("send", radio_send, 1);
    chk("tx_data", radio_tx_data, exp_b);
    chk("send_ren", radio_enable, 1);
    @(negedge clk);
    chk("send_once", radio_send, 0);
    chk("tx_ready", cmd_ready, 1);
    chk("tx_count", buf_count, q.size());
    chk("tx_empty", buf_empty, q.size() == 0);
    chk("tx_ren_off", radio_enable, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n = 1'b0; enable = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_chan = '0;
    sensor_valid = '0; sensor_data = '0; radio_busy = 1'b0; radio_rx_valid = 1'b0;
    radio_rx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_req", sensor_req, 0);
    chk("rst_strobes", {mem_we, mem_re, radio_send, radio_enable}, 0);
    chk("rst_errs", {err_ovf, err_udf, err_tmo}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_count", buf_count, 0);
    chk("rst_empty", buf_empty, 1);
    chk("rst_full", buf_full, 0);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);

    do_sample(2, 8'hA5, 0);
    do_tx(0);
    do_rx(8'h3C, 5);
    do_tx(3);

    // Fill past capacity, then drain past empty; pointers wrap along the way.
    for (int i = 0; i < 5; i++)
      do_sample(int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 3)));
    do_rx(8'($urandom), 0);
    for (int i = 0; i < 5; i++) do_tx(int'($urandom_range(0, 3)));

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: do_sample(int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 3)));
        1: do_rx(8'($urandom), int'($urandom_range(0, 4)));
        default: do_tx(int'($urandom_range(0, 3)));
      endcase
    end

    // NOP is consumed without side effects.
    issue(2'b00, 0);
    chk("nop_ready", cmd_ready, 1);
    chk("nop_strobes", {mem_we, mem_re, radio_send, radio_enable}, 0);
    chk("nop_errs", {err_ovf, err_udf}, 0);
    chk("nop_count", buf_count, q.size());

    // Drop enable while waiting on a busy radio.
    while (q.size() > 1) do_tx(0);
    if (q.size() == 0) do_sample(1, 8'h5E, 1);
    radio_busy = 1'b1;
    issue(2'b10, 0);
    @(negedge clk);
    @(negedge clk);
    chk("dis_in_txwait", {radio_enable, radio_send}, 2'b10);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_ren", radio_enable, 0);
    chk("dis_no_send", radio_send, 0);
    chk("dis_ready", cmd_ready, 0);
    chk("dis_count", buf_count, q.size());
    @(negedge clk);
    chk("dis_no_send2", radio_send, 0);
    enable = 1'b1;
    radio_busy = 1'b0;
    @(negedge clk);
    do_tx(1);

    // SAMPLE whose sensor never answers.
    do_rx(8'h77, 0);
    sensor_valid = '0;
    issue(2'b01, 3);
    chk("hang_req", sensor_req, 4'b1000);
`ifdef SNC_TIMEOUT_EN
    t = 0;
    while (err_tmo !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_tmo_exp = 1;
    chk("tmo_delay", t, 16);
    chk("tmo_req_off", sensor_req, 0);
    chk("tmo_ready", cmd_ready, 1);
    @(negedge clk);
    chk("tmo_once", err_tmo, 0);
    chk("tmo_count", buf_count, q.size());
`else
    t = 0;
    repeat (40) begin
      @(negedge clk);
      t++;
    end
    chk("hang_no_tmo", err_tmo, 0);
    chk("hang_req_held", sensor_req, 4'b1000);
    chk("hang_wait_cycles", t, 40);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("hang_recover", cmd_ready, 1);
`endif

    // Asynchronous reset in the middle of SENSE.
    issue(2'b01, 0);
    chk("mid_req", sensor_req, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", sensor_req, 0);
    chk("arst_ren", radio_enable, 0);
    chk("arst_count", buf_count, 0);
    chk("arst_empty", buf_empty, 1);
    q.delete();
    wr_idx = 0;
    rd_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_sample(3, 8'hC3, 2);
    do_tx(2);

    chk("we_total", n_we_seen, n_we_exp);
    chk("send_total", n_send_seen, n_send_exp);
    chk("tmo_total", n_tmo_seen, n_tmo_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_node_ctrl.md
# sensor_node_ctrl

- Parametrised command-driven sequencer for a wireless sensor node, replacing the fixed 8-bit, single-sensor controller.
- Moves data between N sensor channels, a single-port data memory used as a circular buffer, and the radio.
- Accepts one command at a time over a valid/ready handshake and reports buffer occupancy and error pulses.
- Sits between the node's command source and the sensor/memory/radio blocks.

## Interface
Parameters:
- DATA_W, 8, data width of sensor, memory and radio paths
- ADDR_W, 8, memory address width
- DEPTH, 256, buffer entries used; 2 ≤ DEPTH ≤ 2**ADDR_W
- NUM_SENSORS, 4, sensor channel count; CH_W = max(1, $clog2(NUM_SENSORS))
- TIMEOUT_CYCLES, 1024, wait limit; used only with the timeout feature

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - rst_n  in  1  asynchronous active-low reset
- Control and command:
  - enable  in  1  synchronous run enable
  - cmd_valid  in  1  command offered
  - cmd_ready  out  1  command can be accepted
  - cmd_op  in  2  00 NOP, 01 SAMPLE, 10 TX, 11 RX
  - cmd_chan  in  CH_W  sensor channel for SAMPLE
- Sensor:
  - sensor_req  out  NUM_SENSORS  one-hot sample request
  - sensor_valid  in  NUM_SENSORS  per-channel data valid
  - sensor_data  in  NUM_SENSORS*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- Memory:
  - mem_addr  out  ADDR_W  memory address
  - mem_wdata  out  DATA_W  write data
  - mem_we  out  1  write strobe
  - mem_re  out  1  read strobe
  - mem_rdata  in  DATA_W  read data, valid 1 cycle after mem_re
- Radio:
  - radio_enable  out  1  radio power/enable
  - radio_busy  in  1  radio cannot take a byte
  - radio_send  out  1  1-cycle transmit strobe
  - radio_tx_data  out  DATA_W  transmit byte
  - radio_rx_valid  in  1  received byte valid
  - radio_rx_data  in  DATA_W  received byte
- Status:
  - buf_count  out  ADDR_W+1  entries held
  - buf_full  out  1  buf_count == DEPTH
  - buf_empty  out  1  buf_count == 0
  - err_ovf  out  1  1-cycle pulse: write command rejected because the buffer is full
  - err_udf  out  1  1-cycle pulse: TX rejected because the buffer is empty
  - err_tmo  out  1  1-cycle pulse: timeout

## Operation
- States: IDLE, SENSE, RX_WAIT, MEM_WR, MEM_RD, RD_WAIT, TX_WAIT.
- cmd_ready = enable && state==IDLE. A command is accepted when cmd_valid && cmd_ready.
- NOP: consumed; no state change.
- SAMPLE:
  - If buf_full: pulse err_ovf and stay in IDLE.
  - Otherwise go to SENSE, with sensor_req[cmd_chan]=1 for the whole SENSE state.
  - When sensor_valid[chan] is high, latch that channel's data and go to MEM_WR.
- RX:
  - If buf_full: pulse err_ovf and stay in IDLE.
  - Otherwise go to RX_WAIT, with radio_enable=1.
  - When radio_rx_valid is high, latch radio_rx_data and go to MEM_WR.
- MEM_WR: mem_we=1, mem_addr=wr_ptr, mem_wdata=latched data. Then wr_ptr advances (wraps DEPTH-1→0), buf_count increments, next state IDLE.
- TX:
  - If buf_empty: pulse err_udf and stay in IDLE.
  - Otherwise go to MEM_RD: mem_re=1, mem_addr=rd_ptr.
  - RD_WAIT: latch mem_rdata.
  - TX_WAIT (radio_enable=1): on the first cycle with radio_busy=0, assert radio_send=1 with radio_tx_data. rd_ptr advances with wrap, buf_count decrements, next state IDLE.
- radio_enable is 1 only in RX_WAIT, MEM_RD, RD_WAIT and TX_WAIT.
- enable low in any state: next cycle state=IDLE and all strobes/requests 0. Pointers, count and data are kept; the in-flight command is dropped.
- Strobes (mem_we, mem_re, radio_send, err_*) are registered and never last more than 1 cycle per command.

## Timing
- Reset values: every output 0 except buf_empty=1; wr_ptr, rd_ptr and buf_count are 0.
- SAMPLE accepted at cycle N with sensor_valid already high:
  - SENSE at N+1
  - mem_we at N+2
  - cmd_ready high again at N+3
- TX accepted at N with radio_busy=0:
  - mem_re at N+1
  - radio_send at N+3
  - cmd_ready at N+4
- An error pulse is asserted in cycle N+1. cmd_ready stays high.
- buf_count/full/empty update in the cycle after the mem_we or radio_send strobe.

## Configuration
- SNC_TIMEOUT_EN defined: a counter runs in SENSE, RX_WAIT and TX_WAIT.
  - After TIMEOUT_CYCLES cycles in the state, pulse err_tmo and return to IDLE.
  - No pointer or count change.
- Undefined: those states wait indefinitely. err_tmo is tied to 0.

## Test plan
- Reset, then SAMPLE chan 2 with sensor_data ch2=0xA5 and valid → sensor_req=0100, mem_we at addr 0 with 0xA5, buf_count=1.
- RX with radio_rx_data=0x3C after 5 cycles, then TX with radio_busy high for 3 cycles → 0x3C written, then read back; radio_send asserted once, after busy falls, with 0x3C; buf_empty=1.
- DEPTH=4: five SAMPLEs → 5th gives err_ovf pulse, no mem_we, buf_full=1. Four TXs then one more → err_udf. wr_ptr/rd_ptr wrap to 0.
- enable dropped during TX_WAIT → no radio_send, state IDLE, buf_count unchanged. Reasserting enable lets TX re-run.
- rst_n asserted mid-SENSE → outputs zero immediately (asynchronously), buf_empty=1.
- With SNC_TIMEOUT_EN and TIMEOUT_CYCLES=16: SAMPLE with valid never high → err_tmo 16 cycles after entering SENSE, then IDLE.
